// File: rtl/multiply_pipe.sv
// Two-stage valid/ready wrapper around a combinational multiplier with RISC-V
// MUL/MULH/MULHSU/MULHU decode and synchronous flush.
module multiply_pipe #(
  parameter int unsigned p_width = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [1:0]         op_i,
  input  logic [p_width-1:0] a_i,
  input  logic [p_width-1:0] b_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [p_width-1:0] result_o,
  output logic               busy_o
);

  logic                 r_s1_valid;
  logic [p_width-1:0]   r_s1_a;
  logic [p_width-1:0]   r_s1_b;
  logic [1:0]           r_s1_op;
  logic                 r_s2_valid;
  logic [p_width-1:0]   r_s2_result;

  logic                 w_s2_adv;
  logic                 w_s1_adv;
  logic                 w_in_xfer;
  logic                 w_a_signed;
  logic                 w_b_signed;
  logic [2*p_width-1:0] w_a_ext;
  logic [2*p_width-1:0] w_b_ext;
  logic [2*p_width-1:0] w_product;
  logic [p_width-1:0]   w_sel;

  assign w_s2_adv  = !r_s2_valid || ready_i;
  assign w_s1_adv  = !r_s1_valid || w_s2_adv;
  assign w_in_xfer = valid_i && w_s1_adv;

  always_comb begin
    w_a_signed = 1'b0;
    w_b_signed = 1'b0;
    case (r_s1_op)
      2'b01:   begin w_a_signed = 1'b1; w_b_signed = 1'b1; end
      2'b10:   w_a_signed = 1'b1;
      default: ;
    endcase
  end

  // Extending both operands to 2*p_width makes a modular unsigned multiply
  // yield the correct two's-complement product for every signedness mix.
  assign w_a_ext   = {{p_width{w_a_signed & r_s1_a[p_width-1]}}, r_s1_a};
  assign w_b_ext   = {{p_width{w_b_signed & r_s1_b[p_width-1]}}, r_s1_b};
  assign w_product = w_a_ext * w_b_ext;
  assign w_sel     = (r_s1_op == 2'b00) ? w_product[p_width-1:0]
                                        : w_product[2*p_width-1:p_width];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_s1_valid  <= 1'b0;
      r_s1_a      <= '0;
      r_s1_b      <= '0;
      r_s1_op     <= 2'b00;
      r_s2_valid  <= 1'b0;
      r_s2_result <= '0;
    end else if (flush_i) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      if (w_s1_adv) begin
        r_s1_valid <= w_in_xfer;
      end
      if (w_in_xfer) begin
        r_s1_a  <= a_i;
        r_s1_b  <= b_i;
        r_s1_op <= op_i;
      end
      if (w_s2_adv) begin
        r_s2_valid  <= r_s1_valid;
        r_s2_result <= w_sel;
      end
    end
  end

  assign ready_o  = w_s1_adv;
  assign valid_o  = r_s2_valid;
  assign result_o = r_s2_result;
  assign busy_o   = r_s1_valid || r_s2_valid;

endmodule

// File: tb/tb_multiply_pipe.sv
// Directed bench for multiply_pipe at p_width=4: op sweep, sign corners,
// streaming, backpressure, flush and asynchronous reset.
module tb_multiply_pipe;

  localparam int unsigned W = 4;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         flush_i = 1'b0;
  logic         valid_i = 1'b0;
  logic         ready_o;
  logic [1:0]   op_i = 2'b00;
  logic [W-1:0] a_i = '0;
  logic [W-1:0] b_i = '0;
  logic         valid_o;
  logic         ready_i = 1'b1;
  logic [W-1:0] result_o;
  logic         busy_o;

  int checks = 0;
  int errors = 0;

  multiply_pipe #(.p_width(W)) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .flush_i  (flush_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .op_i     (op_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .result_o (result_o),
    .busy_o   (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    valid_i = 1'b1;
    op_i    = op;
    a_i     = a;
    b_i     = b;
  endtask

  // Reference via integer arithmetic on interpreted operand values.
  function automatic logic [W-1:0] ref_mul(input logic [1:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    int av;
    int bv;
    int p;
    logic [2*W-1:0] p8;
    av = int'(a);
    bv = int'(b);
    if ((op == 2'd1 || op == 2'd2) && a[W-1]) av = av - (1 << W);
    if (op == 2'd1 && b[W-1]) bv = bv - (1 << W);
    p  = av * bv;
    p8 = p[2*W-1:0];
    return (op == 2'd0) ? p8[W-1:0] : p8[2*W-1:W];
  endfunction

  logic [1:0]   ops [4];
  logic [W-1:0] sweep_exp [4];
  logic [W-1:0] corner_exp [4];
  logic [1:0]   s_op [8];
  logic [W-1:0] s_a [8];
  logic [W-1:0] s_b [8];
  logic [W-1:0] exp_a;
  logic [W-1:0] exp_b;
  logic [W-1:0] exp_c;

  initial begin
    ops        = '{2'd0, 2'd1, 2'd2, 2'd3};
    sweep_exp  = '{4'hE, 4'hF, 4'hF, 4'h1};
    corner_exp = '{4'h0, 4'h4, 4'hC, 4'h4};

    // Reset state
    #2;
    chk("rst_valid_o", 32'(valid_o), 0);
    chk("rst_result_o", 32'(result_o), 0);
    chk("rst_busy_o", 32'(busy_o), 0);
    chk("rst_ready_o", 32'(ready_o), 1);
    tick();
    rst_ni = 1'b1;
    tick();

    // Op sweep a=F b=2
    for (int i = 0; i < 4; i++) begin
      drive(ops[i], 4'hF, 4'h2);
      tick();
      valid_i = 1'b0;
      chk("sweep_lat_n", 32'(valid_o), 0);
      tick();
      chk("sweep_valid", 32'(valid_o), 1);
      chk("sweep_result", 32'(result_o), 32'(sweep_exp[i]));
      tick();
    end

    // Sign corner a=8 b=8
    for (int i = 0; i < 4; i++) begin
      drive(ops[i], 4'h8, 4'h8);
      tick();
      valid_i = 1'b0;
      tick();
      chk("corner_valid", 32'(valid_o), 1);
      chk("corner_result", 32'(result_o), 32'(corner_exp[i]));
      tick();
    end

    // Back-to-back stream
    for (int i = 0; i < 8; i++) begin
      s_op[i] = 2'($urandom_range(0, 3));
      s_a[i]  = 4'($urandom_range(0, 15));
      s_b[i]  = 4'($urandom_range(0, 15));
    end
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) drive(s_op[i], s_a[i], s_b[i]);
      else valid_i = 1'b0;
      chk("stream_ready", 32'(ready_o), 1);
      tick();
      if (i >= 1) begin
        chk("stream_valid", 32'(valid_o), 1);
        chk("stream_result", 32'(result_o), 32'(ref_mul(s_op[i-1], s_a[i-1], s_b[i-1])));
      end
    end
    tick();
    chk("stream_drained", 32'(busy_o), 0);

    // Backpressure
    exp_a = ref_mul(2'd3, 4'h7, 4'h9);
    exp_b = ref_mul(2'd1, 4'hB, 4'h5);
    exp_c = ref_mul(2'd0, 4'h6, 4'h3);
    ready_i = 1'b0;
    drive(2'd3, 4'h7, 4'h9);
    chk("bp_ready_1", 32'(ready_o), 1);
    tick();
    drive(2'd1, 4'hB, 4'h5);
    chk("bp_ready_2", 32'(ready_o), 1);
    tick();
    drive(2'd0, 4'h6, 4'h3);
    chk("bp_ready_3", 32'(ready_o), 0);
    tick();
    chk("bp_hold_valid", 32'(valid_o), 1);
    chk("bp_hold_result", 32'(result_o), 32'(exp_a));
    chk("bp_ready_held", 32'(ready_o), 0);
    tick();
    chk("bp_stable_result", 32'(result_o), 32'(exp_a));
    chk("bp_stable_valid", 32'(valid_o), 1);
    ready_i = 1'b1;
    #1;
    chk("bp_release_ready", 32'(ready_o), 1);
    tick();
    valid_i = 1'b0;
    chk("bp_drain_b", 32'(result_o), 32'(exp_b));
    tick();
    chk("bp_drain_c_valid", 32'(valid_o), 1);
    chk("bp_drain_c", 32'(result_o), 32'(exp_c));
    tick();
    chk("bp_empty", 32'(valid_o), 0);

    // Flush with both stages full and input present
    drive(2'd3, 4'hF, 4'hF);
    tick();
    drive(2'd3, 4'hD, 4'hE);
    tick();
    chk("fl_busy_before", 32'(busy_o), 1);
    drive(2'd3, 4'hC, 4'hC);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    valid_i = 1'b0;
    chk("fl_valid_o", 32'(valid_o), 0);
    chk("fl_busy_o", 32'(busy_o), 0);
    tick();
    chk("fl_valid_o_2", 32'(valid_o), 0);
    tick();
    chk("fl_valid_o_3", 32'(valid_o), 0);

    // Asynchronous reset mid-stream
    drive(2'd3, 4'hE, 4'hE);
    tick();
    drive(2'd3, 4'h9, 4'h9);
    tick();
    valid_i = 1'b0;
    chk("ar_pre_valid", 32'(valid_o), 1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("ar_valid_o", 32'(valid_o), 0);
    chk("ar_result_o", 32'(result_o), 0);
    chk("ar_busy_o", 32'(busy_o), 0);
    tick();
    rst_ni = 1'b1;
    tick();
    chk("ar_post_idle", 32'(valid_o), 0);
    drive(2'd0, 4'h3, 4'h5);
    tick();
    valid_i = 1'b0;
    chk("ar_first_lat", 32'(valid_o), 0);
    tick();
    chk("ar_first_valid", 32'(valid_o), 1);
    chk("ar_first_result", 32'(result_o), 32'(4'hF));
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
